// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: opcodes, instruction formats, ALU ops and the
// decoded bundle that travels from decode to execute.
package decode_stage_pkg;

    localparam int unsigned XLEN_MAX = 64;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } aluOperations_t;

    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_rtype_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } instruction_itype_t;

    typedef struct packed {
        logic [6:0] imm_hi;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm_lo;
        logic [6:0] opcode;
    } instruction_stype_t;

    typedef struct packed {
        logic       imm12;
        logic [5:0] imm10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm4_1;
        logic       imm11;
        logic [6:0] opcode;
    } instruction_btype_t;

    typedef struct packed {
        logic [19:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } instruction_utype_t;

    typedef struct packed {
        logic       imm20;
        logic [9:0] imm10_1;
        logic       imm11;
        logic [7:0] imm19_12;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_jtype_t;

    typedef union packed {
        instruction_rtype_t rtype;
        instruction_itype_t itype;
        instruction_stype_t stype;
        instruction_btype_t btype;
        instruction_utype_t utype;
        instruction_jtype_t jtype;
    } instruction_t;

    // Wide fields are held at XLEN_MAX; the stage slices them down to XLEN.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        aluOperations_t      alu_op;
        logic                alu_src_imm;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [2:0]          mem_size;
        logic                branch;
        logic                jump;
        logic                illegal;
    } decoded_t;

    function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] val);
        return {{(XLEN_MAX - 32){val[31]}}, val};
    endfunction

    // alt selects SUB over ADD and SRA over SRL; other funct3 values ignore it.
    function automatic aluOperations_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I/RV64I instruction decoder: raw instruction to decoded bundle.
// The pc field is left zero; the stage fills it in.
module decode_stage_instr_decoder
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  instruction_t i_instr,
    output decoded_t     o_dec
);

    localparam bit Rv64 = (XLEN == 64);

    logic [31:0] w_raw;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_legal;
    decoded_t    w_dec;

    assign w_raw    = i_instr;
    assign w_opcode = i_instr.rtype.opcode;
    assign w_funct3 = i_instr.rtype.funct3;
    assign w_funct7 = i_instr.rtype.funct7;

    assign w_imm_i = {{20{i_instr.itype.imm[11]}}, i_instr.itype.imm};
    assign w_imm_s = {{20{i_instr.stype.imm_hi[6]}}, i_instr.stype.imm_hi, i_instr.stype.imm_lo};
    assign w_imm_b = {{19{i_instr.btype.imm12}}, i_instr.btype.imm12, i_instr.btype.imm11,
                      i_instr.btype.imm10_5, i_instr.btype.imm4_1, 1'b0};
    assign w_imm_u = {i_instr.utype.imm, 12'b0};
    assign w_imm_j = {{11{i_instr.jtype.imm20}}, i_instr.jtype.imm20, i_instr.jtype.imm19_12,
                      i_instr.jtype.imm11, i_instr.jtype.imm10_1, 1'b0};

    always_comb begin
        w_dec   = '0;
        w_legal = 1'b1;
        case (w_opcode)
            OPCODE_OP: begin
                w_dec.rs1       = i_instr.rtype.rs1;
                w_dec.rs2       = i_instr.rtype.rs2;
                w_dec.rd        = i_instr.rtype.rd;
                w_dec.reg_write = 1'b1;
                w_dec.alu_op    = alu_from_funct3(w_funct3, w_funct7 == FUNCT7_ALT);
                if (w_funct7 == FUNCT7_ALT) begin
                    w_legal = (w_funct3 == FUNCT3_ADD_SUB) || (w_funct3 == FUNCT3_SRL_SRA);
                end else begin
                    w_legal = (w_funct7 == FUNCT7_BASE);
                end
            end
            OPCODE_OP_IMM: begin
                w_dec.rs1         = i_instr.itype.rs1;
                w_dec.rd          = i_instr.itype.rd;
                w_dec.imm         = sext32(w_imm_i);
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.alu_op      = alu_from_funct3(w_funct3,
                                                    (w_funct3 == FUNCT3_SRL_SRA) && w_raw[30]);
                // RV64 shifts borrow instr[25] as shamt[5], so only funct6 is checked there.
                if (w_funct3 == FUNCT3_SLL) begin
                    w_legal = Rv64 ? (w_raw[31:26] == 6'b000000) : (w_funct7 == FUNCT7_BASE);
                end else if (w_funct3 == FUNCT3_SRL_SRA) begin
                    w_legal = Rv64 ? ((w_raw[31:26] == 6'b000000) || (w_raw[31:26] == 6'b010000))
                                   : ((w_funct7 == FUNCT7_BASE) || (w_funct7 == FUNCT7_ALT));
                end
            end
            OPCODE_LOAD: begin
                w_dec.rs1         = i_instr.itype.rs1;
                w_dec.rd          = i_instr.itype.rd;
                w_dec.imm         = sext32(w_imm_i);
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.mem_read    = 1'b1;
                w_dec.mem_size    = w_funct3;
                case (w_funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                    3'b011, 3'b110:                         w_legal = Rv64;
                    default:                                w_legal = 1'b0;
                endcase
            end
            OPCODE_STORE: begin
                w_dec.rs1         = i_instr.stype.rs1;
                w_dec.rs2         = i_instr.stype.rs2;
                w_dec.imm         = sext32(w_imm_s);
                w_dec.alu_src_imm = 1'b1;
                w_dec.mem_write   = 1'b1;
                w_dec.mem_size    = w_funct3;
                w_legal           = (w_funct3 <= (Rv64 ? 3'd3 : 3'd2));
            end
            OPCODE_BRANCH: begin
                w_dec.rs1    = i_instr.btype.rs1;
                w_dec.rs2    = i_instr.btype.rs2;
                w_dec.imm    = sext32(w_imm_b);
                w_dec.alu_op = ALU_SUB;
                w_dec.branch = 1'b1;
                w_legal      = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            end
            OPCODE_JAL: begin
                w_dec.rd          = i_instr.jtype.rd;
                w_dec.imm         = sext32(w_imm_j);
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.jump        = 1'b1;
            end
            OPCODE_JALR: begin
                w_dec.rs1         = i_instr.itype.rs1;
                w_dec.rd          = i_instr.itype.rd;
                w_dec.imm         = sext32(w_imm_i);
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.jump        = 1'b1;
                w_legal           = (w_funct3 == 3'b000);
            end
            OPCODE_LUI, OPCODE_AUIPC: begin
                w_dec.rd          = i_instr.utype.rd;
                w_dec.imm         = sext32(w_imm_u);
                w_dec.alu_op      = (w_opcode == OPCODE_LUI) ? ALU_PASSB : ALU_ADD;
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
                w_dec.rs1 = i_instr.itype.rs1;
                w_dec.rd  = i_instr.itype.rd;
                w_dec.imm = sext32(w_imm_i);
            end
            default: w_legal = 1'b0;
        endcase

        if (!w_legal) begin
            w_dec.illegal   = 1'b1;
            w_dec.reg_write = 1'b0;
            w_dec.mem_read  = 1'b0;
            w_dec.mem_write = 1'b0;
            w_dec.branch    = 1'b0;
            w_dec.jump      = 1'b0;
        end
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one-cycle registered decode with valid/ready handshake,
// optional 2-entry skid buffer and a flush that drops everything held or incoming.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_instr,
    input  logic [XLEN-1:0] i_in_pc,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_pc,
    output logic [4:0]      o_out_rs1,
    output logic [4:0]      o_out_rs2,
    output logic [4:0]      o_out_rd,
    output logic [XLEN-1:0] o_out_imm,
    output logic [3:0]      o_out_alu_op,
    output logic            o_out_alu_src_imm,
    output logic            o_out_reg_write,
    output logic            o_out_mem_read,
    output logic            o_out_mem_write,
    output logic [2:0]      o_out_mem_size,
    output logic            o_out_branch,
    output logic            o_out_jump,
    output logic            o_out_illegal
);

    decoded_t w_dec;
    decoded_t w_bundle;
    logic     w_accept;
    logic     w_main_free;

    decoded_t r_main;
    decoded_t r_skid;
    logic     r_main_valid;
    logic     r_skid_valid;

    decode_stage_instr_decoder #(
        .XLEN (XLEN)
    ) u_instr_decoder (
        .i_instr (instruction_t'(i_in_instr)),
        .o_dec   (w_dec)
    );

    always_comb begin
        w_bundle    = w_dec;
        w_bundle.pc = XLEN_MAX'(i_in_pc);
    end

    assign o_in_ready  = SKID_EN ? !r_skid_valid : (!r_main_valid || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_main_free = !r_main_valid || i_out_ready;

    // With SKID_EN=0 the skid is never written: in_ready is low whenever main is stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main <= w_bundle;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid       <= w_bundle;
        end
    end

    assign o_out_valid       = r_main_valid;
    assign o_out_pc          = r_main.pc[XLEN-1:0];
    assign o_out_rs1         = r_main.rs1;
    assign o_out_rs2         = r_main.rs2;
    assign o_out_rd          = r_main.rd;
    assign o_out_imm         = r_main.imm[XLEN-1:0];
    assign o_out_alu_op      = r_main.alu_op;
    assign o_out_alu_src_imm = r_main.alu_src_imm;
    assign o_out_reg_write   = r_main.reg_write;
    assign o_out_mem_read    = r_main.mem_read;
    assign o_out_mem_write   = r_main.mem_write;
    assign o_out_mem_size    = r_main.mem_size;
    assign o_out_branch      = r_main.branch;
    assign o_out_jump        = r_main.jump;
    assign o_out_illegal     = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (XLEN=64, skid enabled): hand-decoded vectors,
// stall/skid ordering, flush and asynchronous reset.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu;
        logic       src_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        ctrl_t       ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;

    logic        o_in_ready, o_out_valid;
    logic [63:0] o_out_pc, o_out_imm;
    logic [4:0]  o_out_rs1, o_out_rs2, o_out_rd;
    logic [3:0]  o_out_alu_op;
    logic        o_out_alu_src_imm, o_out_reg_write, o_out_mem_read, o_out_mem_write;
    logic [2:0]  o_out_mem_size;
    logic        o_out_branch, o_out_jump, o_out_illegal;
    ctrl_t       obs_ctrl;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_out = 0;
    logic [63:0] pc_next = 64'hA5A5_0000_0000_1000;
    exp_t        vecs[$];
    exp_t        sb[$];
    exp_t        cur_exp;

    decode_stage #(
        .XLEN    (64),
        .SKID_EN (1'b1)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_flush           (flush),
        .i_in_valid        (in_valid),
        .o_in_ready        (o_in_ready),
        .i_in_instr        (in_instr),
        .i_in_pc           (in_pc),
        .o_out_valid       (o_out_valid),
        .i_out_ready       (out_ready),
        .o_out_pc          (o_out_pc),
        .o_out_rs1         (o_out_rs1),
        .o_out_rs2         (o_out_rs2),
        .o_out_rd          (o_out_rd),
        .o_out_imm         (o_out_imm),
        .o_out_alu_op      (o_out_alu_op),
        .o_out_alu_src_imm (o_out_alu_src_imm),
        .o_out_reg_write   (o_out_reg_write),
        .o_out_mem_read    (o_out_mem_read),
        .o_out_mem_write   (o_out_mem_write),
        .o_out_mem_size    (o_out_mem_size),
        .o_out_branch      (o_out_branch),
        .o_out_jump        (o_out_jump),
        .o_out_illegal     (o_out_illegal)
    );

    always #5 clk = ~clk;

    assign obs_ctrl = {o_out_rs1, o_out_rs2, o_out_rd, o_out_alu_op, o_out_alu_src_imm,
                       o_out_reg_write, o_out_mem_read, o_out_mem_write, o_out_mem_size,
                       o_out_branch, o_out_jump, o_out_illegal};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] instr, input logic [63:0] imm,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input aluOperations_t alu, input logic src, input logic rw,
                           input logic mr, input logic mw, input logic [2:0] size,
                           input logic br, input logic jmp, input logic ill);
        exp_t e;
        e.instr = instr;
        e.pc    = '0;
        e.imm   = imm;
        e.ctrl  = {rs1, rs2, rd, 4'(alu), src, rw, mr, mw, size, br, jmp, ill};
        vecs.push_back(e);
    endtask

    task automatic present(input int idx);
        cur_exp    = vecs[idx];
        cur_exp.pc = pc_next;
        pc_next    = pc_next + 64'd4;
        in_instr   = cur_exp.instr;
        in_pc      = cur_exp.pc;
        in_valid   = 1'b1;
    endtask

    task automatic wait_accept();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 64'(o_in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input int idx);
        present(idx);
        wait_accept();
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) return;
            @(posedge clk);
            #1;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Transfers are judged at the negedge before the edge that performs them.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (o_out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 64'(o_out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("pc[%h]", e.instr), o_out_pc, e.pc);
                    check($sformatf("imm[%h]", e.instr), o_out_imm, e.imm);
                    check($sformatf("ctrl[%h]", e.instr), 64'(obs_ctrl), 64'(e.ctrl));
                end
            end
            if (in_valid && o_in_ready) sb.push_back(cur_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int          base;
        logic [63:0] pc_a;

        //       instr          imm                     rs1 rs2 rd alu        src rw mr mw size br j ill
        add_vec(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, ALU_ADD,   1, 1, 0, 0, 3'd0, 0, 0, 0);
        add_vec(32'h0020A423, 64'd8,                   1, 2, 0, ALU_ADD,   1, 0, 0, 1, 3'd2, 0, 0, 0);
        add_vec(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, ALU_SUB,   0, 0, 0, 0, 3'd0, 1, 0, 0);
        add_vec(32'h000000EF, 64'd0,                   0, 0, 1, ALU_ADD,   1, 1, 0, 0, 3'd0, 0, 1, 0);
        add_vec(32'h00000000, 64'd0,                   0, 0, 0, ALU_ADD,   0, 0, 0, 0, 3'd0, 0, 0, 1);
        add_vec(32'h402081B3, 64'd0,                   1, 2, 3, ALU_SUB,   0, 1, 0, 0, 3'd0, 0, 0, 0);
        add_vec(32'h123452B7, 64'h0000_0000_1234_5000, 0, 0, 5, ALU_PASSB, 1, 1, 0, 0, 3'd0, 0, 0, 0);
        add_vec(32'h40325213, 64'h403,                 4, 0, 4, ALU_SRA,   1, 1, 0, 0, 3'd0, 0, 0, 0);
        add_vec(32'h01013303, 64'd16,                  2, 0, 6, ALU_ADD,   1, 1, 1, 0, 3'd3, 0, 0, 0);
        add_vec(32'h4020C1B3, 64'd0,                   1, 2, 3, ALU_XOR,   0, 0, 0, 0, 3'd0, 0, 0, 1);
        add_vec(32'h00002063, 64'd0,                   0, 0, 0, ALU_SUB,   0, 0, 0, 0, 3'd0, 0, 0, 1);
        add_vec(32'h8000B393, 64'hFFFF_FFFF_FFFF_F800, 1, 0, 7, ALU_SLTU,  1, 1, 0, 0, 3'd0, 0, 0, 0);
        add_vec(32'h800000EF, 64'hFFFF_FFFF_FFF0_0000, 0, 0, 1, ALU_ADD,   1, 1, 0, 0, 3'd0, 0, 1, 0);
        add_vec(32'h04001093, 64'h40,                  0, 0, 1, ALU_SLL,   1, 0, 0, 0, 3'd0, 0, 0, 1);

        // Reset state
        #2 rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(o_out_valid), 64'd0);
        check("rst_imm", o_out_imm, 64'd0);
        check("rst_ctrl", 64'(obs_ctrl), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(o_in_ready), 64'd1);

        // Back-to-back decode of every vector
        out_ready = 1'b1;
        base = n_out;
        foreach (vecs[i]) send(i);
        wait_drain();
        check("stream_count", 64'(n_out - base), 64'(vecs.size()));

        // Stall with skid: A to main, B to skid, C held off
        out_ready = 1'b0;
        base = n_out;
        pc_a = pc_next;
        send(0);
        send(1);
        present(2);
        repeat (3) @(posedge clk);
        #1;
        check("skid_in_ready", 64'(o_in_ready), 64'd0);
        check("stall_out_valid", 64'(o_out_valid), 64'd1);
        check("stall_pc_hold", o_out_pc, pc_a);
        out_ready = 1'b1;
        wait_accept();
        wait_drain();
        check("skid_emit_count", 64'(n_out - base), 64'd3);

        // Flush with skid full and a new instruction offered
        out_ready = 1'b0;
        send(3);
        send(4);
        present(5);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(o_out_valid), 64'd0);
        check("flush_in_ready", 64'(o_in_ready), 64'd1);
        base = n_out;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_no_emit", 64'(n_out - base), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(6);
        send(7);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(o_out_valid), 64'd0);
        check("async_rst_imm", o_out_imm, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(o_in_ready), 64'd1);
        check("post_rst_out_valid", 64'(o_out_valid), 64'd0);
        out_ready = 1'b1;
        base = n_out;
        send(8);
        wait_drain();
        check("post_rst_emit_count", 64'(n_out - base), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
